// File: rtl/hazard_ctrl.sv
// Pipeline sequencing controller: load-use stall, MEM branch flush and data-memory freeze,
// with a small FSM that parks a branch flush arriving during a freeze until memory is ready.
module hazard_ctrl #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             startin,
    input  logic [4:0]       id_rs,
    input  logic [4:0]       id_rt,
    input  logic             id_uses_rt,
    input  logic             ex_mem_read,
    input  logic [4:0]       ex_rt,
    input  logic             mem_branch_taken,
    input  logic             dmem_busy,
    output logic             pc_write,
    output logic             if_id_write,
    output logic             if_id_flush,
    output logic             id_ex_bubble,
    output logic             id_ex_hold,
    output logic             ex_mem_flush,
    output logic             ex_mem_hold,
    output logic [1:0]       state,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] flush_cnt
);

    typedef enum logic [1:0] {
        RUN        = 2'b00,
        MEM_WAIT   = 2'b01,
        FLUSH_PEND = 2'b10,
        UNUSED     = 2'b11
    } state_t;

    typedef enum logic [1:0] {
        M_NORMAL,
        M_FREEZE,
        M_FLUSH,
        M_LU_STALL
    } mode_t;

    state_t cur_state;
    state_t nxt_state;
    mode_t  mode;
    logic   load_use;
    logic   stall_inc;
    logic   flush_inc;

    assign load_use = ex_mem_read && (ex_rt != 5'd0) &&
                      ((ex_rt == id_rs) || (id_uses_rt && (ex_rt == id_rt)));

    always_ff @(posedge clk) begin
        if (startin) begin
            cur_state <= RUN;
        end else begin
            cur_state <= nxt_state;
        end
    end

    // RUN, MEM_WAIT and the unreachable encoding share one decision: MEM_WAIT only
    // exists so the freeze is visible on the state output.
    always_comb begin
        nxt_state = RUN;
        mode      = M_NORMAL;
        case (cur_state)
            FLUSH_PEND: begin
                if (dmem_busy) begin
                    mode      = M_FREEZE;
                    nxt_state = FLUSH_PEND;
                end else begin
                    mode      = M_FLUSH;
                    nxt_state = RUN;
                end
            end
            default: begin
                if (dmem_busy) begin
                    mode      = M_FREEZE;
                    nxt_state = mem_branch_taken ? FLUSH_PEND : MEM_WAIT;
                end else if (mem_branch_taken) begin
                    mode      = M_FLUSH;
                end else if (load_use) begin
                    mode      = M_LU_STALL;
                end
            end
        endcase
    end

    always_comb begin
        pc_write     = 1'b1;
        if_id_write  = 1'b1;
        if_id_flush  = 1'b0;
        id_ex_bubble = 1'b0;
        id_ex_hold   = 1'b0;
        ex_mem_flush = 1'b0;
        ex_mem_hold  = 1'b0;
        if (startin) begin
            pc_write     = 1'b0;
            if_id_write  = 1'b0;
            if_id_flush  = 1'b1;
            id_ex_bubble = 1'b1;
            ex_mem_flush = 1'b1;
        end else begin
            case (mode)
                M_FREEZE: begin
                    pc_write    = 1'b0;
                    if_id_write = 1'b0;
                    id_ex_hold  = 1'b1;
                    ex_mem_hold = 1'b1;
                end
                M_FLUSH: begin
                    if_id_flush  = 1'b1;
                    id_ex_bubble = 1'b1;
                    ex_mem_flush = 1'b1;
                end
                M_LU_STALL: begin
                    pc_write     = 1'b0;
                    if_id_write  = 1'b0;
                    id_ex_bubble = 1'b1;
                end
                default: begin
                end
            endcase
        end
    end

    assign stall_inc = !startin && ((mode == M_FREEZE) || (mode == M_LU_STALL));
    assign flush_inc = !startin && (mode == M_FLUSH);

    // Performance counters saturate so long runs never wrap back to small values.
    always_ff @(posedge clk) begin
        if (startin) begin
            stall_cnt <= '0;
            flush_cnt <= '0;
        end else begin
            if (stall_inc && (stall_cnt != {CNT_W{1'b1}})) begin
                stall_cnt <= stall_cnt + CNT_W'(1);
            end
            if (flush_inc && (flush_cnt != {CNT_W{1'b1}})) begin
                flush_cnt <= flush_cnt + CNT_W'(1);
            end
        end
    end

    assign state = cur_state;

endmodule

// File: tb/tb_hazard_ctrl.sv
// Bench for hazard_ctrl: directed scenarios followed by random traffic, all checked
// against a cycle-level reference model; a CNT_W=2 copy exercises counter saturation.
module tb_hazard_ctrl;

    logic       clk = 1'b0;
    logic       startin;
    logic [4:0] id_rs, id_rt, ex_rt;
    logic       id_uses_rt, ex_mem_read, mem_branch_taken, dmem_busy;

    logic        pc_write, if_id_write, if_id_flush, id_ex_bubble, id_ex_hold, ex_mem_flush, ex_mem_hold;
    logic [1:0]  state;
    logic [15:0] stall_cnt, flush_cnt;

    logic        s_pc_write, s_if_id_write, s_if_id_flush, s_id_ex_bubble, s_id_ex_hold;
    logic        s_ex_mem_flush, s_ex_mem_hold;
    logic [1:0]  s_state;
    logic [1:0]  s_stall_cnt, s_flush_cnt;

    int checks = 0;
    int errors = 0;

    // reference model: pending flush / memory wait flags plus plain integer counters
    bit m_pend = 0;
    bit m_wait = 0;
    int m_stall = 0, m_flush = 0;

    localparam logic [6:0] EXP_NORMAL = 7'b1100000;
    localparam logic [6:0] EXP_FREEZE = 7'b0000101;
    localparam logic [6:0] EXP_FLUSH  = 7'b1111010;
    localparam logic [6:0] EXP_STALL  = 7'b0001000;
    localparam logic [6:0] EXP_RESET  = 7'b0011010;

    hazard_ctrl dut (
        .clk(clk), .startin(startin), .id_rs(id_rs), .id_rt(id_rt), .id_uses_rt(id_uses_rt),
        .ex_mem_read(ex_mem_read), .ex_rt(ex_rt), .mem_branch_taken(mem_branch_taken),
        .dmem_busy(dmem_busy), .pc_write(pc_write), .if_id_write(if_id_write),
        .if_id_flush(if_id_flush), .id_ex_bubble(id_ex_bubble), .id_ex_hold(id_ex_hold),
        .ex_mem_flush(ex_mem_flush), .ex_mem_hold(ex_mem_hold), .state(state),
        .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
    );

    hazard_ctrl #(.CNT_W(2)) dut_s (
        .clk(clk), .startin(startin), .id_rs(id_rs), .id_rt(id_rt), .id_uses_rt(id_uses_rt),
        .ex_mem_read(ex_mem_read), .ex_rt(ex_rt), .mem_branch_taken(mem_branch_taken),
        .dmem_busy(dmem_busy), .pc_write(s_pc_write), .if_id_write(s_if_id_write),
        .if_id_flush(s_if_id_flush), .id_ex_bubble(s_id_ex_bubble), .id_ex_hold(s_id_ex_hold),
        .ex_mem_flush(s_ex_mem_flush), .ex_mem_hold(s_ex_mem_hold), .state(s_state),
        .stall_cnt(s_stall_cnt), .flush_cnt(s_flush_cnt)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    // One clock cycle: apply inputs, check at the falling edge, advance the model.
    task automatic cycle(input logic rst, input logic busy, input logic taken, input logic mr,
                         input logic [4:0] ert, input logic [4:0] rs, input logic [4:0] rt,
                         input logic urt);
        logic [6:0] exp_ctrl;
        logic       lu;
        int         exp_state;
        bit         do_stall, do_flush;
        startin = rst; dmem_busy = busy; mem_branch_taken = taken; ex_mem_read = mr;
        ex_rt = ert; id_rs = rs; id_rt = rt; id_uses_rt = urt;
        @(negedge clk);
        lu = mr && (ert != 0) && ((ert == rs) || (urt && (ert == rt)));
        exp_state = m_pend ? 2 : (m_wait ? 1 : 0);
        do_stall = 0; do_flush = 0;
        if (rst)                 exp_ctrl = EXP_RESET;
        else if (busy)           begin exp_ctrl = EXP_FREEZE; do_stall = 1; end
        else if (m_pend || taken) begin exp_ctrl = EXP_FLUSH; do_flush = 1; end
        else if (lu)             begin exp_ctrl = EXP_STALL; do_stall = 1; end
        else                     exp_ctrl = EXP_NORMAL;
        check("ctrl", {25'd0, pc_write, if_id_write, if_id_flush, id_ex_bubble, id_ex_hold,
                       ex_mem_flush, ex_mem_hold}, {25'd0, exp_ctrl});
        check("state", {30'd0, state}, exp_state);
        check("stall_cnt", {16'd0, stall_cnt}, (m_stall > 65535) ? 65535 : m_stall);
        check("flush_cnt", {16'd0, flush_cnt}, (m_flush > 65535) ? 65535 : m_flush);
        check("small_stall_cnt", {30'd0, s_stall_cnt}, (m_stall > 3) ? 3 : m_stall);
        check("small_flush_cnt", {30'd0, s_flush_cnt}, (m_flush > 3) ? 3 : m_flush);
        if (rst) begin
            m_pend = 0; m_wait = 0; m_stall = 0; m_flush = 0;
        end else begin
            if (busy) begin
                if (!m_pend) begin
                    if (taken) begin m_pend = 1; m_wait = 0; end
                    else m_wait = 1;
                end
            end else begin
                m_pend = 0; m_wait = 0;
            end
            if (do_stall) m_stall++;
            if (do_flush) m_flush++;
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        startin = 1'b1; dmem_busy = 0; mem_branch_taken = 0; ex_mem_read = 0;
        ex_rt = 0; id_rs = 0; id_rt = 0; id_uses_rt = 0;
        @(posedge clk); #1;
        cycle(1, 0, 0, 0, 0, 0, 0, 0);

        // load-use on rs, then release
        cycle(0, 0, 0, 1, 5'd8, 5'd8, 5'd0, 0);
        cycle(0, 0, 0, 0, 5'd8, 5'd8, 5'd0, 0);
        check("t1_stall_is_1", {16'd0, stall_cnt}, 32'd1);
        // r0 destination and unused rt never stall
        cycle(0, 0, 0, 1, 5'd0, 5'd0, 5'd0, 1);
        cycle(0, 0, 0, 1, 5'd5, 5'd1, 5'd5, 0);
        cycle(0, 0, 0, 1, 5'd5, 5'd1, 5'd5, 1);
        // taken branch wins over load-use
        cycle(0, 0, 1, 1, 5'd8, 5'd8, 5'd0, 0);
        check("t3_flush_is_1", {16'd0, flush_cnt}, 32'd1);
        // three-cycle freeze
        cycle(0, 1, 0, 0, 0, 0, 0, 0);
        check("t4_state_wait", {30'd0, state}, 32'd1);
        cycle(0, 1, 0, 0, 0, 0, 0, 0);
        cycle(0, 1, 0, 0, 0, 0, 0, 0);
        cycle(0, 0, 0, 0, 0, 0, 0, 0);
        check("t4_stall_is_5", {16'd0, stall_cnt}, 32'd5);
        // branch arriving during a freeze is parked then flushed once
        cycle(0, 1, 1, 0, 0, 0, 0, 0);
        cycle(0, 1, 0, 0, 0, 0, 0, 0);
        cycle(0, 1, 0, 0, 0, 0, 0, 0);
        check("t5_state_pend", {30'd0, state}, 32'd2);
        cycle(0, 0, 0, 0, 0, 0, 0, 0);
        cycle(0, 0, 0, 0, 0, 0, 0, 0);
        check("t5_flush_is_2", {16'd0, flush_cnt}, 32'd2);
        // reset with a flush pending
        cycle(0, 1, 1, 0, 0, 0, 0, 0);
        cycle(1, 1, 1, 0, 0, 0, 0, 0);
        cycle(0, 0, 0, 0, 0, 0, 0, 0);
        check("t6_flush_cleared", {16'd0, flush_cnt}, 32'd0);
        // five-cycle freeze saturates the 2-bit counter
        for (int i = 0; i < 5; i++) cycle(0, 1, 0, 0, 0, 0, 0, 0);
        cycle(0, 0, 0, 0, 0, 0, 0, 0);
        check("t6_small_sat", {30'd0, s_stall_cnt}, 32'd3);

        for (int i = 0; i < 400; i++) begin
            cycle(($urandom_range(0, 49) == 0), ($urandom_range(0, 2) == 0),
                  ($urandom_range(0, 3) == 0), ($urandom_range(0, 1) == 1),
                  5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
                  5'($urandom_range(0, 3)), ($urandom_range(0, 1) == 1));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
